// File: rtl/view_angle_accum.sv
// view_angle_accum: per-frame camera yaw/pitch accumulator.
// Mouse deltas and held-key steps are gathered in saturating pending
// accumulators and applied once per frame, three cycles after frame_start.
// Yaw wraps in (-1268, 1268]. Pitch clamps to +/-PITCH_LIMIT.
// Optional pitch channel: define VIEW_PITCH_EN to build it in. When it is
// undefined, pitch is tied to zero and delta_dy is ignored.
module view_angle_accum #(
  parameter int KEY_STEP    = 8,
  parameter int PITCH_LIMIT = 317
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        delta_valid,
  output logic        delta_ready,
  input  logic [7:0]  delta_dx,
  input  logic [7:0]  delta_dy,
  input  logic        key_left,
  input  logic        key_right,
  output logic [15:0] yaw,
  output logic [15:0] pitch,
  output logic        angle_valid
);

  typedef enum logic [1:0] {IDLE, APPLY_YAW, APPLY_PITCH, PUBLISH} state_t;

  state_t             state_q;
  logic signed [11:0] pend_dx_q, snap_dx_q;
  logic signed [15:0] yaw_q, yaw_new_q;
  logic               valid_q;

  logic               accept;
  logic signed [13:0] key_term_d, dx_ext_d, dx_acc_d;
  logic signed [16:0] yaw_sum_d, yaw_fix_d;
  logic signed [15:0] yaw_wrap_d;

  // Saturate a widened sum back into the symmetric 12-bit pending range.
  function automatic logic signed [11:0] sat12(input logic signed [13:0] v);
    if (v > 14'sd2047)       return 12'sd2047;
    else if (v < -14'sd2047) return -12'sd2047;
    else                     return v[11:0];
  endfunction

  assign delta_ready = (state_q == IDLE);
  assign accept      = delta_valid & delta_ready;
  assign yaw         = yaw_q;
  assign angle_valid = valid_q;

  // Key term and pending-dx sum including any delta taken this cycle.
  always_comb begin
    key_term_d = '0;
    if (key_right && !key_left)      key_term_d = 14'(KEY_STEP);
    else if (key_left && !key_right) key_term_d = -14'(KEY_STEP);
    dx_ext_d = accept ? 14'($signed(delta_dx)) : 14'sd0;
    dx_acc_d = 14'(pend_dx_q) + dx_ext_d;
  end

  // Yaw wrap: the snapshot magnitude is bounded so one correction is enough.
  always_comb begin
    yaw_sum_d = 17'(yaw_q) + 17'(snap_dx_q);
    yaw_fix_d = yaw_sum_d;
    if (yaw_sum_d > 17'sd1268)        yaw_fix_d = yaw_sum_d - 17'sd2536;
    else if (yaw_sum_d <= -17'sd1268) yaw_fix_d = yaw_sum_d + 17'sd2536;
    yaw_wrap_d = yaw_fix_d[15:0];
  end

  // Frame FSM with yaw path, pending dx accumulator and publish strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pend_dx_q <= '0;
      snap_dx_q <= '0;
      yaw_q     <= '0;
      yaw_new_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (frame_start) begin
            snap_dx_q <= sat12(dx_acc_d + key_term_d);
            pend_dx_q <= '0;
            state_q   <= APPLY_YAW;
          end else begin
            pend_dx_q <= sat12(dx_acc_d);
          end
        end
        APPLY_YAW: begin
          yaw_new_q <= yaw_wrap_d;
          state_q   <= APPLY_PITCH;
        end
        APPLY_PITCH: begin
          yaw_q   <= yaw_new_q;
          valid_q <= 1'b1;
          state_q <= PUBLISH;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef VIEW_PITCH_EN
  localparam logic signed [16:0] PLIM = 17'(PITCH_LIMIT);

  logic signed [11:0] pend_dy_q, snap_dy_q;
  logic signed [15:0] pitch_q;
  logic signed [13:0] dy_acc_d;
  logic signed [16:0] pitch_sum_d, pitch_fix_d;

  // Pending-dy sum and clamped pitch candidate.
  always_comb begin
    dy_acc_d    = 14'(pend_dy_q) + (accept ? 14'($signed(delta_dy)) : 14'sd0);
    pitch_sum_d = 17'(pitch_q) + 17'(snap_dy_q);
    pitch_fix_d = pitch_sum_d;
    if (pitch_sum_d > PLIM)       pitch_fix_d = PLIM;
    else if (pitch_sum_d < -PLIM) pitch_fix_d = -PLIM;
  end

  // Pitch channel follows the same FSM; it loads with yaw on the publish edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_dy_q <= '0;
      snap_dy_q <= '0;
      pitch_q   <= '0;
    end else begin
      if (state_q == IDLE) begin
        if (frame_start) begin
          snap_dy_q <= sat12(dy_acc_d);
          pend_dy_q <= '0;
        end else begin
          pend_dy_q <= sat12(dy_acc_d);
        end
      end else if (state_q == APPLY_PITCH) begin
        pitch_q <= pitch_fix_d[15:0];
      end
    end
  end

  assign pitch = pitch_q;
`else
  logic unused_pitch;
  assign unused_pitch = ^{delta_dy, 17'(PITCH_LIMIT)};
  assign pitch        = '0;
`endif

endmodule

// File: tb/tb_view_angle_accum.sv
// Self-checking bench for view_angle_accum: directed scenarios from the
// behavioural rules plus a randomized run against a frame-level model.
module tb_view_angle_accum;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        delta_valid = 1'b0;
  logic        delta_ready;
  logic [7:0]  delta_dx = '0;
  logic [7:0]  delta_dy = '0;
  logic        key_left = 1'b0;
  logic        key_right = 1'b0;
  logic [15:0] yaw, pitch;
  logic        angle_valid;

`ifdef VIEW_PITCH_EN
  localparam bit PITCH_EN = 1'b1;
`else
  localparam bit PITCH_EN = 1'b0;
`endif

  view_angle_accum #(.KEY_STEP(8), .PITCH_LIMIT(317)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .delta_valid(delta_valid), .delta_ready(delta_ready),
    .delta_dx(delta_dx), .delta_dy(delta_dy),
    .key_left(key_left), .key_right(key_right),
    .yaw(yaw), .pitch(pitch), .angle_valid(angle_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: published angles, pending sums, cycles left in frame.
  int m_yaw, m_pitch, m_pdx, m_pdy, m_busy, m_new_yaw, m_new_pitch;
  // Observations from the latest drive_cycle.
  bit obs_ready, exp_ready, obs_valid, exp_valid;
  int obs_yaw, obs_pitch;

  function automatic int sat_p(input int v);
    if (v > 2047) return 2047;
    if (v < -2047) return -2047;
    return v;
  endfunction

  function automatic int wrap_yaw(input int v);
    int r;
    r = (v + 1267) % 2536;
    if (r < 0) r += 2536;
    return r - 1267;
  endfunction

  function automatic int clamp_pitch(input int v);
    if (v > 317) return 317;
    if (v < -317) return -317;
    return v;
  endfunction

  task automatic model_clear();
    m_yaw = 0; m_pitch = 0; m_pdx = 0; m_pdy = 0; m_busy = 0;
    m_new_yaw = 0; m_new_pitch = 0;
  endtask

  // One clock cycle: drive inputs at negedge, advance model, observe after posedge.
  task automatic drive_cycle(input bit v, input int dx, input int dy,
                             input bit fs, input bit kl, input bit kr);
    int adx, ady, key, sdx, sdy;
    @(negedge clk);
    delta_valid = v; delta_dx = dx[7:0]; delta_dy = dy[7:0];
    frame_start = fs; key_left = kl; key_right = kr;
    #1;
    obs_ready = delta_ready;
    exp_ready = (m_busy == 0);
    if (m_busy == 0) begin
      adx = v ? dx : 0;
      ady = (v && PITCH_EN) ? dy : 0;
      if (fs) begin
        key = (kr && !kl) ? 8 : ((kl && !kr) ? -8 : 0);
        sdx = sat_p(m_pdx + adx + key);
        sdy = sat_p(m_pdy + ady);
        m_new_yaw   = wrap_yaw(m_yaw + sdx);
        m_new_pitch = PITCH_EN ? clamp_pitch(m_pitch + sdy) : 0;
        m_pdx = 0; m_pdy = 0; m_busy = 3;
      end else begin
        m_pdx = sat_p(m_pdx + adx);
        m_pdy = sat_p(m_pdy + ady);
      end
    end else begin
      m_busy--;
      if (m_busy == 1) begin
        m_yaw = m_new_yaw; m_pitch = m_new_pitch;
      end
    end
    @(posedge clk); #1;
    obs_valid = angle_valid;
    obs_yaw   = $signed(yaw);
    obs_pitch = $signed(pitch);
    exp_valid = (m_busy == 1);
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Pulse frame_start and watch T+1..T+4 for the publish strobe.
  task automatic run_frame(input bit kl, input bit kr, output int vcount,
                           output int valid_at, output int pub_yaw, output int pub_pitch);
    vcount = 0; valid_at = 0; pub_yaw = 99999; pub_pitch = 99999;
    drive_cycle(1'b0, 0, 0, 1'b1, kl, kr);
    for (int i = 1; i <= 4; i++) begin
      if (obs_valid) begin
        vcount++; valid_at = i; pub_yaw = obs_yaw; pub_pitch = obs_pitch;
      end
      if (i < 4) idle_cycle();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    delta_valid = 1'b0; frame_start = 1'b0; key_left = 1'b0; key_right = 1'b0;
    delta_dx = '0; delta_dy = '0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    #1;
    n_checks++; if ($signed(yaw) !== 16'sd0) begin n_fail++; $display("FAIL reset_yaw: got %0d expected 0", $signed(yaw)); end
    n_checks++; if ($signed(pitch) !== 16'sd0) begin n_fail++; $display("FAIL reset_pitch: got %0d expected 0", $signed(pitch)); end
    n_checks++; if (angle_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", angle_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (delta_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", delta_ready); end
    $display("test_reset: yaw=%0d pitch=%0d ready=%b", $signed(yaw), $signed(pitch), delta_ready);
  endtask

  task automatic test_pos_wrap();
    int vc, va, py, pp;
    do_reset();
    repeat (10) drive_cycle(1'b1, 126, 0, 1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, vc, va, py, pp);
    n_checks++; if (py !== 1260) begin n_fail++; $display("FAIL pos_setup_yaw: got %0d expected 1260", py); end
    drive_cycle(1'b1, 20, 0, 1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, vc, va, py, pp);
    n_checks++; if (py !== -1256) begin n_fail++; $display("FAIL pos_wrap_yaw: got %0d expected -1256", py); end
    n_checks++; if (vc !== 1) begin n_fail++; $display("FAIL pos_wrap_strobes: got %0d expected 1", vc); end
    n_checks++; if (va !== 3) begin n_fail++; $display("FAIL pos_wrap_latency: got T+%0d expected T+3", va); end
    $display("test_pos_wrap: yaw=%0d strobes=%0d at T+%0d", py, vc, va);
  endtask

  task automatic test_neg_wrap();
    int vc, va, py, pp;
    do_reset();
    repeat (10) drive_cycle(1'b1, -126, 0, 1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, vc, va, py, pp);
    n_checks++; if (py !== -1260) begin n_fail++; $display("FAIL neg_setup_yaw: got %0d expected -1260", py); end
    drive_cycle(1'b1, -8, 0, 1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, vc, va, py, pp);
    n_checks++; if (py !== 1268) begin n_fail++; $display("FAIL neg_wrap_yaw: got %0d expected 1268", py); end
    $display("test_neg_wrap: yaw=%0d", py);
  endtask

  task automatic test_saturation_keys();
    int vc, va, py, pp;
    do_reset();
    repeat (20) drive_cycle(1'b1, 127, 0, 1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b1, vc, va, py, pp);
    n_checks++; if (py !== -489) begin n_fail++; $display("FAIL sat_key_right_yaw: got %0d expected -489", py); end
    do_reset();
    run_frame(1'b1, 1'b0, vc, va, py, pp);
    n_checks++; if (py !== -8) begin n_fail++; $display("FAIL key_left_yaw: got %0d expected -8", py); end
    run_frame(1'b1, 1'b1, vc, va, py, pp);
    n_checks++; if (py !== -8) begin n_fail++; $display("FAIL key_both_yaw: got %0d expected -8", py); end
    repeat (3) drive_cycle(1'b1, -127, 0, 1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b1, vc, va, py, pp);
    n_checks++; if (py !== -381) begin n_fail++; $display("FAIL key_right_delta_yaw: got %0d expected -381", py); end
    $display("test_saturation_keys: final yaw=%0d", py);
  endtask

  task automatic test_pitch_clamp();
    int vc, va, py, pp;
    do_reset();
`ifdef VIEW_PITCH_EN
    repeat (3) drive_cycle(1'b1, 0, 100, 1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, vc, va, py, pp);
    n_checks++; if (pp !== 300) begin n_fail++; $display("FAIL pitch_setup: got %0d expected 300", pp); end
    drive_cycle(1'b1, 0, 40, 1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, vc, va, py, pp);
    n_checks++; if (pp !== 317) begin n_fail++; $display("FAIL pitch_clamp_pos: got %0d expected 317", pp); end
    repeat (6) drive_cycle(1'b1, 0, -128, 1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, vc, va, py, pp);
    n_checks++; if (pp !== -317) begin n_fail++; $display("FAIL pitch_clamp_neg: got %0d expected -317", pp); end
`else
    repeat (3) drive_cycle(1'b1, 5, 100, 1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, vc, va, py, pp);
    n_checks++; if (pp !== 0) begin n_fail++; $display("FAIL pitch_tied_zero: got %0d expected 0", pp); end
    n_checks++; if (py !== 15) begin n_fail++; $display("FAIL pitch_off_yaw: got %0d expected 15", py); end
`endif
    $display("test_pitch_clamp: pitch=%0d yaw=%0d", pp, py);
  endtask

  task automatic test_handshake();
    int vc, va, py, pp, extra;
    do_reset();
    drive_cycle(1'b1, 5, 0, 1'b0, 1'b0, 1'b0);                // idle transfer
    drive_cycle(1'b1, 5, 0, 1'b1, 1'b0, 1'b0);                // T: accepted, counts
    n_checks++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL hs_ready_T: got %b expected 1", obs_ready); end
    drive_cycle(1'b1, 5, 0, 1'b0, 1'b0, 1'b0);                // T+1
    n_checks++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL hs_ready_T1: got %b expected 0", obs_ready); end
    drive_cycle(1'b1, 5, 0, 1'b1, 1'b0, 1'b0);                // T+2: stray frame_start
    n_checks++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL hs_ready_T2: got %b expected 0", obs_ready); end
    n_checks++; if (obs_valid !== 1'b1 || obs_yaw !== 10) begin n_fail++; $display("FAIL hs_publish: got valid=%b yaw=%0d expected valid=1 yaw=10", obs_valid, obs_yaw); end
    drive_cycle(1'b1, 5, 0, 1'b0, 1'b0, 1'b0);                // T+3
    n_checks++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL hs_ready_T3: got %b expected 0", obs_ready); end
    drive_cycle(1'b1, 5, 0, 1'b0, 1'b0, 1'b0);                // T+4: transfer resumes
    n_checks++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL hs_ready_T4: got %b expected 1", obs_ready); end
    extra = 0;
    repeat (6) begin idle_cycle(); if (obs_valid) extra++; end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL hs_stray_frame: got %0d strobes expected 0", extra); end
    run_frame(1'b0, 1'b0, vc, va, py, pp);
    n_checks++; if (py !== 15) begin n_fail++; $display("FAIL hs_next_frame_yaw: got %0d expected 15", py); end
    $display("test_handshake: second frame yaw=%0d", py);
  endtask

  task automatic test_random();
    int dx, dy, errs;
    bit v, fs, kl, kr;
    do_reset();
    errs = 0;
    for (int i = 0; i < 800; i++) begin
      v  = ($urandom_range(3, 0) != 0);
      dx = int'($urandom_range(255, 0)) - 128;
      dy = int'($urandom_range(255, 0)) - 128;
      fs = ($urandom_range(5, 0) == 0);
      kl = $urandom_range(1, 0) == 1;
      kr = $urandom_range(1, 0) == 1;
      drive_cycle(v, dx, dy, fs, kl, kr);
      n_checks++;
      if (obs_ready !== exp_ready || obs_valid !== exp_valid ||
          obs_yaw !== m_yaw || obs_pitch !== m_pitch) begin
        n_fail++; errs++;
        if (errs <= 10)
          $display("FAIL rand_cycle %0d: got rdy=%b vld=%b yaw=%0d pitch=%0d expected rdy=%b vld=%b yaw=%0d pitch=%0d",
                   i, obs_ready, obs_valid, obs_yaw, obs_pitch, exp_ready, exp_valid, m_yaw, m_pitch);
      end
    end
    $display("test_random: 800 cycles, final yaw=%0d pitch=%0d, errors=%0d", m_yaw, m_pitch, errs);
  endtask

  task automatic test_reset_mid();
    int vc, va, py, pp, stale;
    do_reset();
    repeat (3) drive_cycle(1'b1, 100, 60, 1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, vc, va, py, pp);
    drive_cycle(1'b1, 50, 50, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b0, 0, 0, 1'b1, 1'b0, 1'b1);                // now APPLY_YAW
    idle_cycle();                                             // now APPLY_PITCH
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    #1;
    n_checks++; if ($signed(yaw) !== 16'sd0 || $signed(pitch) !== 16'sd0) begin n_fail++; $display("FAIL mid_reset_angles: got yaw=%0d pitch=%0d expected 0 0", $signed(yaw), $signed(pitch)); end
    n_checks++; if (angle_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b expected 0", angle_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (delta_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b expected 1", delta_ready); end
    stale = 0;
    repeat (6) begin idle_cycle(); if (obs_valid) stale++; end
    n_checks++; if (stale !== 0 || obs_yaw !== 0) begin n_fail++; $display("FAIL mid_reset_stale: got strobes=%0d yaw=%0d expected 0 0", stale, obs_yaw); end
    $display("test_reset_mid: yaw=%0d stale strobes=%0d", obs_yaw, stale);
  endtask

  initial begin
    model_clear();
    test_reset();
    test_pos_wrap();
    test_neg_wrap();
    test_saturation_keys();
    test_pitch_clamp();
    test_handshake();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
